// File: rtl/bcd_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seven_seg_scanner
//  Description : Latches four BCD digits on LOAD and scans them onto a
//                4-digit common-anode seven-segment display. A refresh
//                divider sets how long each digit stays selected. Segment
//                decode and anode select are registered.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
//                on digits 3..1. Digit 0 is never blanked.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_WIDTH   = 17
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LOAD,
    input  logic [3:0] THOUSANDS,
    input  logic [3:0] HUNDREDS,
    input  logic [3:0] TENS,
    input  logic [3:0] ONES,
    output logic [3:0] SEG_SELECT_OUT,
    output logic [7:0] HEX_OUT
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = CNT_WIDTH'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] r_refresh_cnt;
    logic                 w_tick;
    logic [3:0]           r_shadow_3;
    logic [3:0]           r_shadow_2;
    logic [3:0]           r_shadow_1;
    logic [3:0]           r_shadow_0;
    logic [3:0]           w_digit;
    logic                 w_blank;
    logic [7:0]           w_hex;
    logic [3:0]           w_sel;

    // Shadow digit capture; holds unless LOAD is asserted.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_shadow_3 <= 4'd0;
            r_shadow_2 <= 4'd0;
            r_shadow_1 <= 4'd0;
            r_shadow_0 <= 4'd0;
        end else if (LOAD) begin
            r_shadow_3 <= THOUSANDS;
            r_shadow_2 <= HUNDREDS;
            r_shadow_1 <= TENS;
            r_shadow_0 <= ONES;
        end
    end

    assign w_tick = (r_refresh_cnt == c_CNT_MAX);

    // Refresh divider: counts 0..REFRESH_DIV-1; the wrap edge is the tick.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_refresh_cnt <= '0;
        end else if (w_tick) begin
            r_refresh_cnt <= '0;
        end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
        end
    end

    // Scan state register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_state <= DIG0;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Scan next-state: advance one digit per tick, wrapping DIG3 -> DIG0.
    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                DIG0:    w_state_next = DIG1;
                DIG1:    w_state_next = DIG2;
                DIG2:    w_state_next = DIG3;
                DIG3:    w_state_next = DIG0;
                default: w_state_next = DIG0;
            endcase
        end
    end

    // Select the shadow digit for the current scan position and decide blanking.
    always_comb begin
        w_digit = r_shadow_0;
        w_blank = 1'b0;
        case (r_state)
            DIG0:    w_digit = r_shadow_0;
            DIG1:    w_digit = r_shadow_1;
            DIG2:    w_digit = r_shadow_2;
            DIG3:    w_digit = r_shadow_3;
            default: w_digit = r_shadow_0;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (r_state)
            DIG3:    w_blank = (r_shadow_3 == 4'd0);
            DIG2:    w_blank = (r_shadow_3 == 4'd0) && (r_shadow_2 == 4'd0);
            DIG1:    w_blank = (r_shadow_3 == 4'd0) && (r_shadow_2 == 4'd0)
                               && (r_shadow_1 == 4'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    // Active-low segment decode, DP off; non-BCD codes blank the digit.
    always_comb begin
        w_hex = 8'hFF;
        if (!w_blank) begin
            case (w_digit)
                4'd0:    w_hex = 8'hC0;
                4'd1:    w_hex = 8'hF9;
                4'd2:    w_hex = 8'hA4;
                4'd3:    w_hex = 8'hB0;
                4'd4:    w_hex = 8'h99;
                4'd5:    w_hex = 8'h92;
                4'd6:    w_hex = 8'h82;
                4'd7:    w_hex = 8'hF8;
                4'd8:    w_hex = 8'h80;
                4'd9:    w_hex = 8'h90;
                default: w_hex = 8'hFF;
            endcase
        end
    end

    assign w_sel = ~(4'b0001 << r_state);

    // Output register: all segments and anodes off during reset.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            SEG_SELECT_OUT <= 4'b1111;
            HEX_OUT        <= 8'hFF;
        end else begin
            SEG_SELECT_OUT <= w_sel;
            HEX_OUT        <= w_hex;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seven_seg_scanner
//  Description : Scoreboard bench for bcd_seven_seg_scanner with
//                REFRESH_DIV=4. Stimulus pushes the expected output of
//                every edge; a monitor pops and compares after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seven_seg_scanner;

    localparam int REFRESH_DIV = 4;
    localparam int CNT_WIDTH   = 3;

    logic       clk;
    logic       RESETN;
    logic       LOAD;
    logic [3:0] THOUSANDS;
    logic [3:0] HUNDREDS;
    logic [3:0] TENS;
    logic [3:0] ONES;
    logic [3:0] SEG_SELECT_OUT;
    logic [7:0] HEX_OUT;

    typedef struct {
        logic [3:0] sel;
        logic [7:0] hex;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference state: refresh count, scan index, shadow digits.
    int         m_cnt;
    int         m_idx;
    logic [3:0] m_sh [4];

    bcd_seven_seg_scanner #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_dut (
        .CLK            (clk),
        .RESETN         (RESETN),
        .LOAD           (LOAD),
        .THOUSANDS      (THOUSANDS),
        .HUNDREDS       (HUNDREDS),
        .TENS           (TENS),
        .ONES           (ONES),
        .SEG_SELECT_OUT (SEG_SELECT_OUT),
        .HEX_OUT        (HEX_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] model_hex(input int idx);
        logic blank;
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 3) blank = (m_sh[3] == 4'd0);
        if (idx == 2) blank = (m_sh[3] == 4'd0) && (m_sh[2] == 4'd0);
        if (idx == 1) blank = (m_sh[3] == 4'd0) && (m_sh[2] == 4'd0) && (m_sh[1] == 4'd0);
`endif
        return blank ? 8'hFF : seg_code(m_sh[idx]);
    endfunction

    // One clock of stimulus: drive inputs, push the expected output of the
    // coming edge, then advance the reference state across that edge.
    task automatic step(input logic rn, input logic ld,
                        input logic [3:0] th, input logic [3:0] hu,
                        input logic [3:0] te, input logic [3:0] on);
        exp_t e;
        @(negedge clk);
        RESETN    = rn;
        LOAD      = ld;
        THOUSANDS = th;
        HUNDREDS  = hu;
        TENS      = te;
        ONES      = on;
        if (!rn) begin
            e.sel = 4'b1111;
            e.hex = 8'hFF;
        end else begin
            e.sel = ~(4'b0001 << m_idx);
            e.hex = model_hex(m_idx);
        end
        exp_q.push_back(e);
        if (!rn) begin
            m_cnt = 0;
            m_idx = 0;
            for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
        end else begin
            if (ld) begin
                m_sh[3] = th;
                m_sh[2] = hu;
                m_sh[1] = te;
                m_sh[0] = on;
            end
            if (m_cnt == REFRESH_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic idle(input int n, input logic [3:0] d);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, d, d, d, d);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (SEG_SELECT_OUT !== e.sel || HEX_OUT !== e.hex) begin
                    n_fail++;
                    $display("FAIL vec%0d sel/hex: got %b/%h expected %b/%h",
                             n_vec, SEG_SELECT_OUT, HEX_OUT, e.sel, e.hex);
                end
            end
        end
    end

    initial begin
        int guard;
        RESETN = 1'b0; LOAD = 1'b0;
        THOUSANDS = 4'd0; HUNDREDS = 4'd0; TENS = 4'd0; ONES = 4'd0;
        m_cnt = 0; m_idx = 0;
        for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;

        // Reset for 3 edges; LOAD during reset must be ignored.
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        step(1'b0, 1'b1, 4'd5, 4'd5, 4'd5, 4'd5);
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Free scan of zeros: 1110, 1101, 1011, 0111, 1110 every 4 edges.
        idle(20, 4'd0);

        // Load 1,2,3,4 then change inputs to 9s without LOAD.
        step(1'b1, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        idle(17, 4'd9);

        // LOAD exactly on the tick edge that moves DIG3 -> DIG0, ONES=7.
        guard = 0;
        while (!(m_idx == 3 && m_cnt == REFRESH_DIV - 1) && guard < 20) begin
            idle(1, 4'd0);
            guard++;
        end
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd7);
        idle(3, 4'd0);

        // Non-BCD value on TENS blanks digit 1.
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'hA, 4'd0);
        idle(16, 4'd0);

        // Load nonzero digits, then reset mid-dwell in DIG2.
        step(1'b1, 1'b1, 4'd8, 4'd6, 4'd5, 4'd2);
        guard = 0;
        while (!(m_idx == 2 && m_cnt == 1) && guard < 20) begin
            idle(1, 4'd0);
            guard++;
        end
        step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(18, 4'd0);

        // Leading-zero pattern 0,0,4,0, then all zeros.
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd4, 4'd0);
        idle(16, 4'd0);
        step(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
        idle(16, 4'd0);

        // Drain the scoreboard with a bounded wait.
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
